hmc_tx_token_gate: RTL and testbench
====================================

# hmc_tx_token_gate

Token-based flow-control gate in the HMC TX path, between the TX flit buffer (AXI-side) and the TX link scrambler/serialiser stage. Each accepted FLIT consumes one HMC input-buffer token. Whole FPW-wide words are held back until enough tokens are available. Token returns (RTC), pre-summed by the RX path, replenish the count.

## Interface
- FPW, 4, flits per word (2,4,6,8)
- LOG_FPW, 2, log2 of FPW (3 for FPW 6/8)
- DWIDTH, FPW*128, data width
- LOG_MAX_HMC_TOKENS, 10, token counter range 0..2^LOG_MAX_HMC_TOKENS
- clk_hmc  in  1  clock; all logic is single clock
- res  in  1  synchronous, active-high reset
- cfg_hmc_tokens  in  LOG_MAX_HMC_TOKENS+1  initial token count from the register file
- cfg_load  in  1  loads cfg_hmc_tokens (INIT only)
- s_data  in  DWIDTH  input word
- s_flit_valid  in  FPW  per-FLIT valid mask
- s_hdr  in  FPW  per-FLIT header mask
- s_tail  in  FPW  per-FLIT tail mask
- s_valid  in  1  word valid
- s_ready  out  1  word accepted when s_valid&&s_ready
- m_data  out  DWIDTH  output word
- m_flit_valid, m_hdr, m_tail  out  FPW each  registered copies of the input masks
- m_valid  out  1  output valid
- m_ready  in  1  downstream ready
- tok_ret_valid  in  1  qualifies tok_ret
- tok_ret  in  LOG_MAX_HMC_TOKENS  tokens returned this cycle
- tokens_avail  out  LOG_MAX_HMC_TOKENS+1  current token count
- stall_cnt  out  16  saturating count of cycles blocked by tokens
- err_overflow  out  1  sticky; token count would have exceeded maximum

## Operation
- States: INIT, RUN.
  - INIT: s_ready=0. On cfg_load, tokens←cfg_hmc_tokens and the state moves to RUN.
  - RUN: cfg_load is ignored. Only res returns the block to INIT.
- pop = popcount(s_flit_valid), range 0..FPW.
- tok_ok = (tokens ≥ pop), compared against the registered count only. Tokens returned in the same cycle are not usable until the next cycle.
- s_ready = RUN && tok_ok && (!m_valid || m_ready).
  - s_ready has no combinational path from tok_ret.
  - s_ready does have a combinational path from m_ready.
- A word with pop=0 and s_valid=1 is accepted and forwarded; it consumes no tokens.
- Update: tokens_next = tokens + (tok_ret_valid ? tok_ret : 0) − (accept ? pop : 0).
  - Compute in LOG_MAX_HMC_TOKENS+2 bits.
  - If the result exceeds 2^LOG_MAX_HMC_TOKENS, saturate at 2^LOG_MAX_HMC_TOKENS and set err_overflow.
- Words are never split: all FLITs of a word pass together.
- stall_cnt increments while RUN && s_valid && !tok_ok && (!m_valid || m_ready). It saturates at 0xFFFF.
- Output stage is a one-deep register. It loads on accept. m_valid clears on m_ready when there is no new accept.

## Timing
- Latency: accept in cycle N → m_valid in N+1. Full throughput is one word per cycle when tokens suffice and m_ready=1.
- Once m_valid=1, m_* are held stable until m_ready.
- Reset values:
  - state=INIT, tokens=0, tokens_avail=0
  - s_ready=0, m_valid=0
  - m_data, m_flit_valid, m_hdr, m_tail = 0
  - stall_cnt=0, err_overflow=0
- Reset mid-operation drops the held output word. Tokens are lost and must be reloaded via cfg_load.
- Simultaneous accept and token return: both apply in the same update.
- tokens_avail is the registered count and reflects the update one cycle after the event.

## Structure
- Package hmc_tx_token_pkg:
  - state enum (INIT, RUN)
  - FLIT_SIZE=128 constant
  - function popcount over an FPW-bit mask
- Sub-module hmc_tx_token_oreg: the one-deep valid/ready output register, parameterised by DWIDTH and FPW.
- Top-level RTL contains the FSM, the token counter and the stall counter.

## Test plan
- Reset then cfg_load with cfg_hmc_tokens=8; stream 3 full words (pop=4) with m_ready=1 → 2 words pass; tokens_avail=0; third word stalls with s_ready=0 and stall_cnt increments each cycle.
- From tokens=0 with a pending pop=4 word, pulse tok_ret_valid with tok_ret=4 → s_ready=1 exactly one cycle later; word emitted the following cycle; tokens_avail returns to 0.
- tokens=2 with s_flit_valid=4'b0011 and simultaneous tok_ret=5 → accepted; tokens_avail=5 next cycle.
- cfg 1020 tokens, tok_ret=10 → tokens_avail=1024 (saturated); err_overflow=1 and stays set until res.
- Hold m_ready=0 for 5 cycles with a word in the output register → m_* stable; s_ready=0; no token change; stall_cnt not incremented.
- Assert res while m_valid=1 and tokens=6 → next cycle m_valid=0, tokens_avail=0, state INIT; a cfg_load issued while in RUN before the reset had no effect.

Source files
------------

// File: rtl/hmc_tx_token_pkg.sv
// hmc_tx_token_pkg: shared state type, flit size and popcount helper for the TX token gate
package hmc_tx_token_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam int FLIT_SIZE = 128;
  localparam int MAX_FPW = 8;
  function automatic logic [3:0] popcount(input logic [MAX_FPW-1:0] m);
    popcount = '0;
    for (int i = 0; i < MAX_FPW; i++) popcount = popcount + {3'b0, m[i]};
  endfunction
endpackage

// File: rtl/hmc_tx_token_oreg.sv
// hmc_tx_token_oreg: one-deep valid/ready output register holding a whole FPW-wide word
module hmc_tx_token_oreg #(
  parameter int DWIDTH = 512,
  parameter int FPW = 4
) (
  input  logic              clk_hmc,
  input  logic              res,
  input  logic              ld,
  input  logic [DWIDTH-1:0] d_data,
  input  logic [FPW-1:0]    d_flit_valid,
  input  logic [FPW-1:0]    d_hdr,
  input  logic [FPW-1:0]    d_tail,
  input  logic              m_ready,
  output logic              free,
  output logic [DWIDTH-1:0] m_data,
  output logic [FPW-1:0]    m_flit_valid,
  output logic [FPW-1:0]    m_hdr,
  output logic [FPW-1:0]    m_tail,
  output logic              m_valid
);
  assign free = !m_valid || m_ready;
  // load on accept, otherwise drain when downstream takes the word
  always_ff @(posedge clk_hmc) begin
    if (res) begin
      m_valid <= 1'b0;
      m_data <= '0;
      m_flit_valid <= '0;
      m_hdr <= '0;
      m_tail <= '0;
    end else if (ld) begin
      m_valid <= 1'b1;
      m_data <= d_data;
      m_flit_valid <= d_flit_valid;
      m_hdr <= d_hdr;
      m_tail <= d_tail;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/hmc_tx_token_gate.sv
// hmc_tx_token_gate: holds back whole TX words until enough HMC input-buffer tokens are available
module hmc_tx_token_gate
  import hmc_tx_token_pkg::*;
#(
  parameter int FPW = 4,
  parameter int LOG_FPW = 2,
  parameter int DWIDTH = FPW * FLIT_SIZE,
  parameter int LOG_MAX_HMC_TOKENS = 10
) (
  input  logic                        clk_hmc,
  input  logic                        res,
  input  logic [LOG_MAX_HMC_TOKENS:0] cfg_hmc_tokens,
  input  logic                        cfg_load,
  input  logic [DWIDTH-1:0]           s_data,
  input  logic [FPW-1:0]              s_flit_valid,
  input  logic [FPW-1:0]              s_hdr,
  input  logic [FPW-1:0]              s_tail,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [DWIDTH-1:0]           m_data,
  output logic [FPW-1:0]              m_flit_valid,
  output logic [FPW-1:0]              m_hdr,
  output logic [FPW-1:0]              m_tail,
  output logic                        m_valid,
  input  logic                        m_ready,
  input  logic                        tok_ret_valid,
  input  logic [LOG_MAX_HMC_TOKENS-1:0] tok_ret,
  output logic [LOG_MAX_HMC_TOKENS:0] tokens_avail,
  output logic [15:0]                 stall_cnt,
  output logic                        err_overflow
);
  localparam int TW = LOG_MAX_HMC_TOKENS + 2;
  localparam logic [TW-1:0] TOK_MAX = TW'(1) << LOG_MAX_HMC_TOKENS;
  state_t state;
  logic [LOG_MAX_HMC_TOKENS:0] tokens;
  logic [MAX_FPW-1:0] mask;
  logic [LOG_FPW:0] pop;
  logic [TW-1:0] tok_next;
  logic tok_ok, free, accept, over, stall;
  // widen the per-flit mask to the helper's fixed width
  always_comb begin
    mask = '0;
    mask[FPW-1:0] = s_flit_valid;
  end
  assign pop = (LOG_FPW + 1)'(popcount(mask));
  assign tok_ok = TW'(tokens) >= TW'(pop);
  assign s_ready = (state == RUN) && tok_ok && free;
  assign accept = s_valid && s_ready;
  assign stall = (state == RUN) && s_valid && !tok_ok && free;
  assign tok_next = TW'(tokens) + (tok_ret_valid ? TW'(tok_ret) : '0) - (accept ? TW'(pop) : '0);
  assign over = tok_next > TOK_MAX;
  assign tokens_avail = tokens;
  // FSM, token counter and stall counter; returned tokens only count from the next cycle
  always_ff @(posedge clk_hmc) begin
    if (res) begin
      state <= INIT;
      tokens <= '0;
      stall_cnt <= '0;
      err_overflow <= 1'b0;
    end else if (state == INIT) begin
      if (cfg_load) begin
        tokens <= cfg_hmc_tokens;
        state <= RUN;
      end
    end else begin
      tokens <= over ? TOK_MAX[LOG_MAX_HMC_TOKENS:0] : tok_next[LOG_MAX_HMC_TOKENS:0];
      if (over) err_overflow <= 1'b1;
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
  hmc_tx_token_oreg #(.DWIDTH(DWIDTH), .FPW(FPW)) u_oreg (
    .clk_hmc(clk_hmc),
    .res(res),
    .ld(accept),
    .d_data(s_data),
    .d_flit_valid(s_flit_valid),
    .d_hdr(s_hdr),
    .d_tail(s_tail),
    .m_ready(m_ready),
    .free(free),
    .m_data(m_data),
    .m_flit_valid(m_flit_valid),
    .m_hdr(m_hdr),
    .m_tail(m_tail),
    .m_valid(m_valid)
  );
endmodule

// File: tb/tb_hmc_tx_token_gate.sv
// tb_hmc_tx_token_gate: directed self-checking bench for the TX token gate
module tb_hmc_tx_token_gate;
  localparam int FPW = 4;
  localparam int DW = 512;
  logic clk_hmc = 0;
  logic res;
  logic [10:0] cfg_hmc_tokens;
  logic cfg_load;
  logic [DW-1:0] s_data;
  logic [3:0] s_flit_valid, s_hdr, s_tail;
  logic s_valid, s_ready;
  logic [DW-1:0] m_data;
  logic [3:0] m_flit_valid, m_hdr, m_tail;
  logic m_valid, m_ready;
  logic tok_ret_valid;
  logic [9:0] tok_ret;
  logic [10:0] tokens_avail;
  logic [15:0] stall_cnt;
  logic err_overflow;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] d1, d2, d3, d4, d5, d6;

  hmc_tx_token_gate dut (
    .clk_hmc(clk_hmc), .res(res), .cfg_hmc_tokens(cfg_hmc_tokens), .cfg_load(cfg_load),
    .s_data(s_data), .s_flit_valid(s_flit_valid), .s_hdr(s_hdr), .s_tail(s_tail),
    .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_flit_valid(m_flit_valid),
    .m_hdr(m_hdr), .m_tail(m_tail), .m_valid(m_valid), .m_ready(m_ready),
    .tok_ret_valid(tok_ret_valid), .tok_ret(tok_ret), .tokens_avail(tokens_avail),
    .stall_cnt(stall_cnt), .err_overflow(err_overflow)
  );

  always #5 clk_hmc = ~clk_hmc;

  task automatic tick();
    @(posedge clk_hmc);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[31:0], exp[31:0]);
    end
  endtask

  initial begin
    d1 = {16{32'h1111_0001}};
    d2 = {16{32'h2222_0002}};
    d3 = {16{32'h3333_0003}};
    d4 = {16{32'h4444_0004}};
    d5 = {16{32'h5555_0005}};
    d6 = {16{32'h6666_0006}};
    res = 1; cfg_hmc_tokens = 0; cfg_load = 0; s_data = '0; s_flit_valid = 0;
    s_hdr = 0; s_tail = 0; s_valid = 0; m_ready = 1; tok_ret_valid = 0; tok_ret = 0;
    tick();
    tick();
    res = 0;
    #1;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_tokens", 32'(tokens_avail), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_err", 32'(err_overflow), 0);
    chk_data("rst_m_data", m_data, '0);
    s_valid = 1; s_flit_valid = 4'hF; s_data = d1;
    #1;
    chk("init_s_ready", 32'(s_ready), 0);
    s_valid = 0;
    cfg_hmc_tokens = 8; cfg_load = 1;
    tick();
    cfg_load = 0;
    chk("load_tokens", 32'(tokens_avail), 8);
    // stream three full words with 8 tokens
    s_valid = 1; s_flit_valid = 4'hF; s_hdr = 4'h1; s_tail = 4'h8; s_data = d1;
    #1;
    chk("w1_s_ready", 32'(s_ready), 1);
    tick();
    s_data = d2;
    #1;
    chk("w1_m_valid", 32'(m_valid), 1);
    chk_data("w1_m_data", m_data, d1);
    chk("w1_tokens", 32'(tokens_avail), 4);
    chk("w2_s_ready", 32'(s_ready), 1);
    tick();
    s_data = d3;
    #1;
    chk_data("w2_m_data", m_data, d2);
    chk("w2_tokens", 32'(tokens_avail), 0);
    chk("w3_s_ready", 32'(s_ready), 0);
    chk("w3_stall0", 32'(stall_cnt), 0);
    tick();
    chk("w3_stall1", 32'(stall_cnt), 1);
    chk("w3_m_valid_drained", 32'(m_valid), 0);
    tick();
    chk("w3_stall2", 32'(stall_cnt), 2);
    // token return is visible only from the next cycle
    tok_ret_valid = 1; tok_ret = 4;
    #1;
    chk("ret_no_comb_path", 32'(s_ready), 0);
    tick();
    tok_ret_valid = 0;
    #1;
    chk("ret_tokens", 32'(tokens_avail), 4);
    chk("ret_s_ready", 32'(s_ready), 1);
    chk("ret_stall3", 32'(stall_cnt), 3);
    tick();
    s_valid = 0;
    #1;
    chk("w3_m_valid", 32'(m_valid), 1);
    chk_data("w3_m_data", m_data, d3);
    chk("w3_tokens", 32'(tokens_avail), 0);
    chk("w3_stall_hold", 32'(stall_cnt), 3);
    // accept and return in the same cycle
    tok_ret_valid = 1; tok_ret = 2;
    tick();
    chk("pre_tokens2", 32'(tokens_avail), 2);
    tok_ret = 5; s_valid = 1; s_flit_valid = 4'b0011; s_hdr = 4'b0001; s_tail = 4'b0010; s_data = d4;
    #1;
    chk("sim_s_ready", 32'(s_ready), 1);
    tick();
    tok_ret_valid = 0;
    s_flit_valid = 4'b0000; s_hdr = 0; s_tail = 0; s_data = d5;
    #1;
    chk("sim_tokens", 32'(tokens_avail), 5);
    chk_data("sim_m_data", m_data, d4);
    chk("sim_m_flit_valid", 32'(m_flit_valid), 32'b0011);
    chk("sim_m_tail", 32'(m_tail), 32'b0010);
    chk("pop0_s_ready", 32'(s_ready), 1);
    tick();
    s_flit_valid = 4'hF; s_data = d6; m_ready = 0;
    #1;
    chk_data("pop0_m_data", m_data, d5);
    chk("pop0_m_flit_valid", 32'(m_flit_valid), 0);
    chk("pop0_tokens", 32'(tokens_avail), 5);
    // backpressure holds the output word and blocks without counting stalls
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_m_valid", 32'(m_valid), 1);
      chk_data("bp_m_data", m_data, d5);
      chk("bp_s_ready", 32'(s_ready), 0);
      chk("bp_tokens", 32'(tokens_avail), 5);
      chk("bp_stall", 32'(stall_cnt), 3);
    end
    m_ready = 1;
    #1;
    chk("bp_release_s_ready", 32'(s_ready), 1);
    tick();
    s_valid = 0; m_ready = 0;
    chk_data("w6_m_data", m_data, d6);
    chk("w6_tokens", 32'(tokens_avail), 1);
    // cfg_load in RUN is ignored
    cfg_hmc_tokens = 100; cfg_load = 1; tok_ret_valid = 1; tok_ret = 5;
    tick();
    cfg_load = 0; tok_ret_valid = 0;
    chk("run_cfg_ignored", 32'(tokens_avail), 6);
    chk("pre_res_m_valid", 32'(m_valid), 1);
    res = 1; m_ready = 1;
    tick();
    res = 0;
    #1;
    chk("res_m_valid", 32'(m_valid), 0);
    chk("res_tokens", 32'(tokens_avail), 0);
    chk("res_s_ready", 32'(s_ready), 0);
    chk_data("res_m_data", m_data, '0);
    chk("res_stall", 32'(stall_cnt), 0);
    // saturation and sticky overflow
    cfg_hmc_tokens = 1020; cfg_load = 1;
    tick();
    cfg_load = 0;
    chk("sat_load", 32'(tokens_avail), 1020);
    tok_ret_valid = 1; tok_ret = 4;
    tick();
    chk("sat_exact_tokens", 32'(tokens_avail), 1024);
    chk("sat_exact_err", 32'(err_overflow), 0);
    tok_ret = 10;
    tick();
    tok_ret_valid = 0;
    chk("sat_tokens", 32'(tokens_avail), 1024);
    chk("sat_err", 32'(err_overflow), 1);
    tick();
    tick();
    chk("sat_err_sticky", 32'(err_overflow), 1);
    chk("sat_tokens_hold", 32'(tokens_avail), 1024);
    res = 1;
    tick();
    res = 0;
    #1;
    chk("sat_err_cleared", 32'(err_overflow), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
